// File: rtl/disp_arbiter_if.sv
// ---------------------------------------------------------------------------
// disp_arbiter_if
//
// Purpose: bundles the content-source requests and data, and the display-side
//          results, for the display arbiter.
//
// Signals:
//   req1, req2  : level requests from src1 (settings) and src2 (alarm/event)
//   data0..2    : 32-bit BCD content per source, digit0 = [3:0]
//   blink_mask  : per-digit blink enable applied to src1 content
//   disp_din    : registered value towards the scanner din
//   grant       : one-hot current owner, bit k = src k
//   disp_chg    : one-cycle pulse marking a change of owner
//
// Modports:
//   master : the clock/alarm/setting side (drives requests and data)
//   slave  : the arbiter (drives disp_din, grant, disp_chg)
// ---------------------------------------------------------------------------
interface disp_arbiter_if;
    logic        req1;
    logic        req2;
    logic [31:0] data0;
    logic [31:0] data1;
    logic [31:0] data2;
    logic [7:0]  blink_mask;
    logic [31:0] disp_din;
    logic [2:0]  grant;
    logic        disp_chg;

    modport master (
        output req1, req2, data0, data1, data2, blink_mask,
        input  disp_din, grant, disp_chg
    );

    modport slave (
        input  req1, req2, data0, data1, data2, blink_mask,
        output disp_din, grant, disp_chg
    );
endinterface

// File: rtl/disp_arbiter.sv
// ---------------------------------------------------------------------------
// disp_arbiter
//
// Purpose: shares the single 8-digit BCD display datapath between three
//          sources. src0 (background clock) owns the display by default;
//          src1 (settings) and src2 (alarm) take it on request, src2 having
//          the higher priority. A granted event source keeps the display for
//          at least HOLD_CYC cycles. disp_din is registered from the owner
//          selected by the registered grant.
//
// Ports:
//   clk : system clock
//   rst : asynchronous, active-high reset
//   bus : disp_arbiter_if.slave (req1/req2, data0..2, blink_mask in;
//         disp_din, grant, disp_chg out)
//
// Parameters:
//   HOLD_CYC  : minimum cycles an event source keeps the display once granted
//   BLINK_CYC : blink half-period in cycles (only with DISP_BLINK_EN)
//
// Configuration macro:
//   DISP_BLINK_EN : when defined, src1 digits selected by blink_mask show a
//                   dash (4'hA) during the high blink phase. When undefined,
//                   blink_mask is ignored and src1 passes through unmodified.
// ---------------------------------------------------------------------------
module disp_arbiter #(
    parameter int HOLD_CYC  = 50_000_000,
    parameter int BLINK_CYC = 12_500_000
) (
    input  logic          clk,
    input  logic          rst,
    disp_arbiter_if.slave bus
);

    localparam int            CW        = $clog2(HOLD_CYC) + 1;
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYC - 1);

    localparam logic [2:0] G_SRC0 = 3'b001;
    localparam logic [2:0] G_SRC1 = 3'b010;
    localparam logic [2:0] G_SRC2 = 3'b100;

    typedef enum logic [1:0] {
        ST_BG     = 2'd0,  // src0 owns the display
        ST_HOLD   = 2'd1,  // event owner, minimum hold still running
        ST_ACTIVE = 2'd2   // event owner, hold satisfied
    } state_t;

    state_t        state, state_nx;
    logic [2:0]    grant_q, grant_nx;
    logic [CW-1:0] hold_cnt, hold_cnt_nx;
    logic [31:0]   din_q, din_nx;
    logic          chg_q;
    logic          owner_req;
    logic [31:0]   data1_shown;

    // -----------------------------------------------------------------------
    // Next-state / next-owner logic
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a default before the case so no path can
        // leave it unassigned and infer a latch.
        state_nx    = state;
        grant_nx    = grant_q;
        hold_cnt_nx = hold_cnt;
        owner_req   = (grant_q[1] & bus.req1) | (grant_q[2] & bus.req2);

        case (state)
            ST_BG: begin
                if (bus.req2) begin
                    state_nx    = ST_HOLD;
                    grant_nx    = G_SRC2;
                    hold_cnt_nx = '0;
                end else if (bus.req1) begin
                    state_nx    = ST_HOLD;
                    grant_nx    = G_SRC1;
                    hold_cnt_nx = '0;
                end
            end

            ST_HOLD: begin
                // src2 may cut into a src1 hold; the owner is otherwise kept
                // for the full hold even if its request drops.
                if (grant_q[1] && bus.req2) begin
                    grant_nx    = G_SRC2;
                    hold_cnt_nx = '0;
                end else if (hold_cnt == HOLD_LAST) begin
                    state_nx    = ST_ACTIVE;
                    hold_cnt_nx = '0;
                end else begin
                    hold_cnt_nx = hold_cnt + CW'(1);
                end
            end

            ST_ACTIVE: begin
                if (grant_q[1] && bus.req2) begin
                    state_nx    = ST_HOLD;
                    grant_nx    = G_SRC2;
                    hold_cnt_nx = '0;
                end else if (!owner_req) begin
                    if (bus.req2) begin
                        state_nx    = ST_HOLD;
                        grant_nx    = G_SRC2;
                        hold_cnt_nx = '0;
                    end else if (bus.req1) begin
                        state_nx    = ST_HOLD;
                        grant_nx    = G_SRC1;
                        hold_cnt_nx = '0;
                    end else begin
                        state_nx = ST_BG;
                        grant_nx = G_SRC0;
                    end
                end
            end

            default: begin
                state_nx    = ST_BG;
                grant_nx    = G_SRC0;
                hold_cnt_nx = '0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // src1 content, optionally with blinking digits
    // -----------------------------------------------------------------------
`ifdef DISP_BLINK_EN
    localparam int            BW         = $clog2(BLINK_CYC) + 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYC - 1);

    logic [BW-1:0] blink_cnt;
    logic          blink_phase;

    // Free-running from reset; independent of who owns the display.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt   <= blink_cnt + BW'(1);
        end
    end

    always_comb begin
        data1_shown = bus.data1;
        for (int i = 0; i < 8; i++) begin
            if (blink_phase && bus.blink_mask[i]) begin
                data1_shown[4*i +: 4] = 4'hA;
            end
        end
    end
`else
    localparam int unused_blink_cyc = BLINK_CYC;
    logic          unused_blink_mask;

    assign unused_blink_mask = ^bus.blink_mask;
    assign data1_shown       = bus.data1;
`endif

    // Display mux driven by the registered grant, so a new owner's data
    // reaches disp_din one cycle after grant changes.
    always_comb begin
        case (grant_q)
            G_SRC1:  din_nx = data1_shown;
            G_SRC2:  din_nx = bus.data2;
            default: din_nx = bus.data0;
        endcase
    end

    // -----------------------------------------------------------------------
    // State and output registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_BG;
            grant_q  <= G_SRC0;
            hold_cnt <= '0;
            din_q    <= '0;
            chg_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            state    <= state_nx;
            grant_q  <= grant_nx;
            hold_cnt <= hold_cnt_nx;
            din_q    <= din_nx;
            chg_q    <= (grant_nx != grant_q);
        end
    end

    assign bus.disp_din = din_q;
    assign bus.grant    = grant_q;
    assign bus.disp_chg = chg_q;

endmodule
